mixcolumns_serial_ctrl: RTL and testbench
=========================================

// Module: mixcolumns_serial_ctrl
// PURPOSE
//  Column-serial MixColumns engine for area-reduced AES round paths. Accepts a 128-bit
//  state over a valid/ready handshake and applies MixColumns through COLS_PER_CYCLE
//  shared ax_modular_multiplier_new instances, stepping a column counter over the 4 columns.
//  Returns the result over a valid/ready handshake. Supports bypass for the final AES round.
// PARAMETERS
//  NB_BYTE         8   bits per byte; only 8 is legal.
//  N_BYTES         16  bytes per state; only 16 is legal.
//  COLS_PER_CYCLE  1   columns processed per cycle; legal values 1, 2, 4.
//                      N_STEPS = 4/COLS_PER_CYCLE.
// PORTS
//  i_clock     in   1    clock; all state changes on the rising edge.
//  i_reset_n   in   1    reset, asynchronous and active-low.
//  i_clear     in   1    synchronous abort; returns to IDLE and drops any state.
//  i_valid     in   1    input state valid.
//  i_bypass    in   1    sampled with i_state; 1 = pass the state through unchanged.
//  i_state     in   128  input state; column c in [127-32c -: 32]; row 0 is the MSB byte.
//  o_ready     out  1    block can accept i_state this cycle.
//  i_ready     in   1    downstream accepts o_state.
//  o_valid     out  1    o_state holds a finished result.
//  o_state     out  128  result, same layout as i_state; registered.
//  o_busy      out  1    FSM is not in IDLE.
// BEHAVIOUR
//  Reset (i_reset_n=0), effective immediately:
//   - FSM=IDLE, step counter=0, working register=0, bypass flag=0.
//   - o_valid=0, o_busy=0, o_state=0.
//   - Reset mid-operation discards the state in progress; there is no partial output.
//  FSM states: IDLE, BUSY, DONE.
//   - IDLE: o_ready=1.
//     On i_valid: latch i_state and i_bypass, set step=0.
//     Next state is DONE if i_bypass=1, otherwise BUSY.
//   - BUSY: o_ready=0. Each cycle, columns step*C .. step*C+C-1 (C=COLS_PER_CYCLE)
//     are routed through the multipliers and written back in place. Then step increments.
//     At step=N_STEPS-1, step wraps to 0 and the FSM goes to DONE.
//   - DONE: o_valid=1; o_state holds its value until accepted.
//     If i_ready=1 and i_valid=0: go to IDLE.
//     If i_ready=1 and i_valid=1: accept the new input on the same edge (o_ready=1
//     in this case) and go to BUSY, or to DONE if bypassed. This gives back-to-back throughput.
//     If i_ready=0: stay in DONE; o_ready=0; the input is stalled.
//  o_ready is combinational: IDLE | (DONE & i_ready).
//  Latency, from the acceptance edge to the first cycle with o_valid=1:
//   - N_STEPS+1 cycles normally; 1 cycle when bypassed.
//   - Sustained throughput: one state per N_STEPS+1 cycles with i_ready tied high.
//  Arithmetic: per column (a0..a3, a0 = MSB byte), over GF(2^8) mod x^8+x^4+x^3+x+1:
//   - b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
//   - xtime reduces with 0x1B.
//  o_state equals the working register; it is meaningful only while o_valid=1.
//  i_clear takes priority over all handshakes but not over reset.
//   - In any state: next state IDLE, o_valid=0 on the next cycle, working register unchanged.
//  i_valid asserted while o_ready=0 is ignored; the source must hold it.
//  Illegal parameters: an elaboration-time $error (BAD_CONF).
// TESTING
//  1. FIPS-197 vector, C=1, i_ready=1:
//     i_state=128'hdb135345_f20a225c_01010101_2d26314c
//     -> o_state=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8.
//     o_valid rises 5 cycles after acceptance.
//  2. Same vector with C=2 and C=4 -> identical result; latency 3 and 2 cycles respectively.
//  3. Bypass: i_bypass=1, i_state=128'h00112233_44556677_8899aabb_ccddeeff
//     -> same value out, o_valid 1 cycle after acceptance.
//  4. Backpressure: hold i_ready=0 for 10 cycles in DONE
//     -> o_state stable, o_ready=0, second i_valid is stalled.
//     Release i_ready -> second input is accepted on the same edge the first result is taken.
//  5. Back-to-back: 8 random states with i_ready=1
//     -> results match the reference model in order; one result every N_STEPS+1 cycles.
//  6. Abort:
//     - Assert i_clear at step 2 -> IDLE next cycle, no o_valid.
//     - Assert i_reset_n=0 mid-BUSY -> all outputs 0 immediately.
//     - A subsequent vector-1 run passes.

Source files
------------

// File: rtl/mixcolumns_serial_ctrl_if.sv
// Handshake bundle for the column-serial MixColumns engine: the input stream
// (valid/bypass/state/o_ready) and the result stream (valid/state/i_ready).
interface mixcolumns_serial_ctrl_if;
    logic         i_valid;
    logic         i_bypass;
    logic [127:0] i_state;
    logic         o_ready;
    logic         i_ready;
    logic         o_valid;
    logic [127:0] o_state;
    logic         o_busy;

    modport master (
        output i_valid, i_bypass, i_state, i_ready,
        input  o_ready, o_valid, o_state, o_busy
    );

    modport slave (
        input  i_valid, i_bypass, i_state, i_ready,
        output o_ready, o_valid, o_state, o_busy
    );
endinterface

// File: rtl/mixcolumns_serial_ctrl.sv
// Column-serial AES MixColumns engine: COLS_PER_CYCLE shared column multipliers
// walk the 4 columns of a latched state in place, with a bypass for the last round.
module mixcolumns_serial_ctrl #(
    parameter int NB_BYTE        = 8,
    parameter int N_BYTES        = 16,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_clear,
    mixcolumns_serial_ctrl_if.slave   bus
);
    localparam int         N_STEPS   = (COLS_PER_CYCLE > 0) ? 4 / COLS_PER_CYCLE : 1;
    localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

    generate
        if (NB_BYTE != 8 || N_BYTES != 16 ||
            !(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_conf
            $error("BAD_CONF: NB_BYTE must be 8, N_BYTES 16, COLS_PER_CYCLE 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    step_reg, step_next;
    logic [127:0]  work_reg, work_next;
    logic [127:0]  busy_result;
    logic          accept;

    logic [31:0]   col_cur  [4];
    logic [1:0]    lane_col [COLS_PER_CYCLE];
    logic [31:0]   lane_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Column c occupies [127-32c -: 32]; column 0 is the most significant word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_cur[gi] = work_reg[127 - 32*gi -: 32];
        end
        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign lane_col[gi] = 2'(32'(step_reg) * COLS_PER_CYCLE + gi);
            assign lane_out[gi] = mix_column(col_cur[lane_col[gi]]);
        end
    endgenerate

    always_comb begin
        logic [31:0] col_new [4];
        for (int c = 0; c < 4; c++) begin
            col_new[c] = col_cur[c];
        end
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
            col_new[lane_col[l]] = lane_out[l];
        end
        busy_result = {col_new[0], col_new[1], col_new[2], col_new[3]};
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            work_reg  <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            work_reg  <= work_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        work_next  = work_reg;
        if (i_clear) begin
            state_next = IDLE;
            step_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        work_next  = bus.i_state;
                        step_next  = '0;
                        state_next = bus.i_bypass ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    work_next = busy_result;
                    if (step_reg == LAST_STEP) begin
                        step_next  = '0;
                        state_next = DONE;
                    end else begin
                        step_next = step_reg + 2'd1;
                    end
                end
                DONE: begin
                    if (accept) begin
                        work_next  = bus.i_state;
                        step_next  = '0;
                        state_next = bus.i_bypass ? DONE : BUSY;
                    end else if (bus.i_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // An abort cycle never signals ready, so a source cannot believe a state was taken.
    always_comb begin
        bus.o_ready = !i_clear && ((state_reg == IDLE) || (state_reg == DONE && bus.i_ready));
        bus.o_valid = (state_reg == DONE);
        bus.o_busy  = (state_reg != IDLE);
        bus.o_state = work_reg;
    end

    assign accept = bus.o_ready && bus.i_valid;
endmodule

// File: tb/tb_mixcolumns_serial_ctrl.sv
// Directed + random bench for mixcolumns_serial_ctrl with a GF(2^8) matrix reference model.
module tb_mixcolumns_serial_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    always #5 clk = ~clk;

    mixcolumns_serial_ctrl_if b1 ();
    mixcolumns_serial_ctrl_if b2 ();
    mixcolumns_serial_ctrl_if b4 ();

    mixcolumns_serial_ctrl #(.NB_BYTE(8), .N_BYTES(16), .COLS_PER_CYCLE(1)) dut1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clear), .bus(b1));
    mixcolumns_serial_ctrl #(.NB_BYTE(8), .N_BYTES(16), .COLS_PER_CYCLE(2)) dut2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clear), .bus(b2));
    mixcolumns_serial_ctrl #(.NB_BYTE(8), .N_BYTES(16), .COLS_PER_CYCLE(4)) dut4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clear), .bus(b4));

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] BYP_VEC  = 128'h00112233_44556677_8899aabb_ccddeeff;

    // Generic GF(2^8) product, polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Circulant matrix [2 3 1 1] applied to every column.
    function automatic logic [127:0] mc_ref(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(coef[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows acceptance.
    task automatic accept1(input logic [127:0] st, input logic byp);
        logic ok = 1'b0;
        logic rdy;
        b1.i_valid  = 1'b1;
        b1.i_state  = st;
        b1.i_bypass = byp;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            rdy = b1.o_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            @(negedge clk);
        end
        b1.i_valid = 1'b0;
        chk_w("accept_within_budget", 32'(ok), 32'd1);
    endtask

    // lat = index of the first post-acceptance cycle with o_valid high (0 = never).
    task automatic wait_valid1(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (b1.o_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, lat2, lat4, got, last_cyc, saw;
        logic [127:0] res2, res4, sa, sb;
        logic [127:0] stq [8];
        logic         rdy;

        rst_n = 1'b0;
        clear = 1'b0;
        b1.i_valid = 1'b0; b1.i_bypass = 1'b0; b1.i_state = '0; b1.i_ready = 1'b1;
        b2.i_valid = 1'b0; b2.i_bypass = 1'b0; b2.i_state = '0; b2.i_ready = 1'b1;
        b4.i_valid = 1'b0; b4.i_bypass = 1'b0; b4.i_state = '0; b4.i_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_w("reset_o_valid", 32'(b1.o_valid), 32'd0);
        chk_w("reset_o_busy",  32'(b1.o_busy),  32'd0);
        chk_w("reset_o_ready", 32'(b1.o_ready), 32'd1);
        chk("reset_o_state", b1.o_state, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 vector, one column per cycle
        accept1(FIPS_IN, 1'b0);
        chk_w("c1_busy", 32'(b1.o_busy), 32'd1);
        wait_valid1(lat);
        chk_w("c1_latency", 32'(lat), 32'd5);
        chk("c1_fips", b1.o_state, FIPS_OUT);
        @(negedge clk);

        // Same vector on the two- and four-lane builds, in parallel
        b2.i_valid = 1'b1; b2.i_state = FIPS_IN;
        b4.i_valid = 1'b1; b4.i_state = FIPS_IN;
        @(posedge clk);
        @(negedge clk);
        b2.i_valid = 1'b0;
        b4.i_valid = 1'b0;
        lat2 = 0; lat4 = 0; res2 = '0; res4 = '0;
        for (int k = 1; k <= 10; k++) begin
            if (b2.o_valid === 1'b1 && lat2 == 0) begin lat2 = k; res2 = b2.o_state; end
            if (b4.o_valid === 1'b1 && lat4 == 0) begin lat4 = k; res4 = b4.o_state; end
            @(negedge clk);
        end
        chk_w("c2_latency", 32'(lat2), 32'd3);
        chk("c2_fips", res2, FIPS_OUT);
        chk_w("c4_latency", 32'(lat4), 32'd2);
        chk("c4_fips", res4, FIPS_OUT);

        // Bypass
        accept1(BYP_VEC, 1'b1);
        wait_valid1(lat);
        chk_w("bypass_latency", 32'(lat), 32'd1);
        chk("bypass_state", b1.o_state, BYP_VEC);
        @(negedge clk);

        // Backpressure: hold the first result, stall the second input
        sa = rand_state();
        sb = rand_state();
        b1.i_ready = 1'b0;
        accept1(sa, 1'b0);
        wait_valid1(lat);
        chk_w("bp_latency", 32'(lat), 32'd5);
        b1.i_valid = 1'b1;
        b1.i_state = sb;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk_w("bp_o_ready_low", 32'(b1.o_ready), 32'd0);
            chk("bp_o_state_hold", b1.o_state, mc_ref(sa));
            chk_w("bp_o_valid_hold", 32'(b1.o_valid), 32'd1);
            @(negedge clk);
        end
        b1.i_ready = 1'b1;
        #1;
        chk_w("bp_release_ready", 32'(b1.o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        b1.i_valid = 1'b0;
        chk_w("bp_second_busy", 32'(b1.o_busy), 32'd1);
        chk_w("bp_first_taken", 32'(b1.o_valid), 32'd0);
        wait_valid1(lat);
        chk_w("bp_second_latency", 32'(lat), 32'd5);
        chk("bp_second_state", b1.o_state, mc_ref(sb));
        @(negedge clk);

        // Back-to-back random states, i_ready tied high
        for (int i = 0; i < 8; i++) stq[i] = rand_state();
        got = 0;
        last_cyc = 0;
        b1.i_valid = 1'b1;
        b1.i_state = stq[0];
        for (int cyc = 0, idx = 0; cyc < 200 && got < 8; cyc++) begin
            if (b1.o_valid === 1'b1) begin
                $display("b2b result %0d: %h", got, b1.o_state);
                chk("b2b_state", b1.o_state, mc_ref(stq[got]));
                if (got > 0) chk_w("b2b_interval", 32'(cyc - last_cyc), 32'd5);
                last_cyc = cyc;
                got++;
            end
            #1;
            rdy = b1.o_ready && b1.i_valid;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                idx++;
                if (idx < 8) b1.i_state = stq[idx];
                else         b1.i_valid = 1'b0;
            end
        end
        b1.i_valid = 1'b0;
        chk_w("b2b_count", 32'(got), 32'd8);
        @(negedge clk);

        // Abort with i_clear at step 2
        accept1(rand_state(), 1'b0);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        chk_w("clear_busy", 32'(b1.o_busy), 32'd0);
        chk_w("clear_valid", 32'(b1.o_valid), 32'd0);
        saw = 0;
        for (int k = 0; k < 8; k++) begin
            if (b1.o_valid !== 1'b0) saw = 1;
            @(negedge clk);
        end
        chk_w("clear_no_valid", 32'(saw), 32'd0);

        // Asynchronous reset mid-operation
        accept1(rand_state(), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_w("areset_busy", 32'(b1.o_busy), 32'd0);
        chk_w("areset_valid", 32'(b1.o_valid), 32'd0);
        chk("areset_state", b1.o_state, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Recovery run
        accept1(FIPS_IN, 1'b0);
        wait_valid1(lat);
        chk_w("recover_latency", 32'(lat), 32'd5);
        chk("recover_fips", b1.o_state, FIPS_OUT);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
